// File: rtl/imem_loader_pkg.sv
// ---------------------------------------------------------------------------
// imem_loader_pkg
//   Shared definitions for the instruction-memory loader: FSM state encoding
//   and the word/address geometry used by the loader and its byte packer.
//   No ports (package).
// ---------------------------------------------------------------------------
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Bytes per instruction word and the byte-address stride between words
  // (identical to the PC+4 stride so the core fetches what was written).
  localparam int          WORD_BYTES = 4;
  localparam logic [31:0] ADDR_STEP  = 32'd4;

endpackage

// File: rtl/imem_loader_word_packer.sv
// ---------------------------------------------------------------------------
// word_packer
//   Shifts host bytes into a 32-bit big-endian word (first byte ends up in
//   bits [31:24]) and flags the byte that completes the word.
// Ports
//   clk          in   1   system clock
//   rst          in   1   asynchronous active-high reset
//   i_clear      in   1   discard partial word and restart the byte count
//   i_shift      in   1   accept i_byte this cycle
//   i_byte       in   8   byte to shift in
//   o_word       out  32  packed word (stable once complete until next shift)
//   o_word_full  out  1   this cycle's shift completes the word
// ---------------------------------------------------------------------------
module word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_shift,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;

  // NOTE: clocked state is updated with non-blocking assignments so every
  // register samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_word <= '0;
      r_cnt  <= '0;
    end else if (i_shift) begin
      r_word <= {r_word[23:0], i_byte};
      r_cnt  <= r_cnt + 2'd1;  // wraps to 0 after the 4th byte
    end
  end

  // Lookahead so the loader can enter WRITE on the edge that takes byte 4.
  assign o_word_full = i_shift && (r_cnt == 2'(WORD_BYTES - 1));
  assign o_word      = r_word;

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Receives a host byte stream
//   (16-bit big-endian word-count header followed by big-endian words),
//   writes each word to consecutive word addresses starting at BASE_ADDR and
//   holds the CPU pipeline until an image has been loaded cleanly.
//
// Build option
//   IMEM_LOADER_CHECKSUM_EN : when defined, one trailing byte (XOR of all
//   data bytes) is required after the last word; a mismatch fails the load.
//
// Ports
//   clk         in   1      system clock
//   rst         in   1      asynchronous active-high reset
//   start       in   1      pulse: begin a new load (honoured in IDLE/DONE)
//   byte_valid  in   1      host byte present
//   byte_data   in   8      host byte
//   byte_ready  out  1      byte accepted this cycle when byte_valid=1
//   wr_en       out  1      memory write strobe, one cycle per word
//   wr_addr     out  32     byte address of the word being written
//   wr_data     out  32     instruction word
//   cpu_hold    out  1      1 = pipeline frozen
//   done        out  1      load finished (sticky until next start)
//   error       out  1      load rejected/failed, valid with done
//   word_count  out  LEN_W  words written by the current/last load
// ---------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256,
  parameter int          LEN_W     = 16
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] word_count
);

  state_t           r_state;
  state_t           w_state_next;

  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_word_count;
  logic [31:0]      r_wr_addr;
  logic             r_done;
  logic             r_error;
  logic             r_cpu_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       r_csum;
`endif

  logic             w_xfer;
  logic             w_start_ok;
  logic             w_shift;
  logic             w_word_full;
  logic [31:0]      w_word;
  logic [LEN_W-1:0] w_len_full;
  logic             w_len_zero;
  logic             w_len_big;
  logic [LEN_W-1:0] w_count_next;
  logic             w_last_word;

  assign w_xfer       = byte_valid && byte_ready;
  // byte_ready is low in IDLE/DONE, so a simultaneous byte is never taken.
  assign w_start_ok   = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_shift      = (r_state == DATA) && w_xfer;
  assign w_len_full   = {r_len[LEN_W-9:0], byte_data};
  assign w_len_zero   = (w_len_full == '0);
  assign w_len_big    = (w_len_full > LEN_W'(MAX_WORDS));
  assign w_count_next = r_word_count + LEN_W'(1);
  assign w_last_word  = (w_count_next == r_len);

  word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_ok),
    .i_shift     (w_shift),
    .i_byte      (byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  // ---- FSM: state register -------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // ---- FSM: next-state logic -----------------------------------------------
  always_comb begin
    // NOTE: defaulting to the current state before the case keeps this block
    // purely combinational (no latch on paths that do not assign it).
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = LEN_HI;
      LEN_HI:  if (w_xfer) w_state_next = LEN_LO;
      LEN_LO:  if (w_xfer) w_state_next = (w_len_zero || w_len_big) ? DONE : DATA;
      DATA:    if (w_word_full) w_state_next = WRITE;
      WRITE: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        w_state_next = w_last_word ? CHK : DATA;
`else
        w_state_next = w_last_word ? DONE : DATA;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:     if (w_xfer) w_state_next = DONE;
`endif
      DONE:    if (start) w_state_next = LEN_HI;
      default: w_state_next = IDLE;
    endcase
  end

  // ---- FSM: outputs decoded from state ---------------------------------------
  always_comb begin
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    case (r_state)
      LEN_HI, LEN_LO, DATA: byte_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:                  byte_ready = 1'b1;
`endif
      WRITE:                wr_en      = 1'b1;
      default: ;
    endcase
  end

  // ---- Length, address/word counters, status flags ---------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len        <= '0;
      r_word_count <= '0;
      r_wr_addr    <= BASE_ADDR;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_len        <= '0;
            r_word_count <= '0;
            r_wr_addr    <= BASE_ADDR;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_cpu_hold   <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum       <= '0;
`endif
          end
        end
        LEN_HI: if (w_xfer) r_len <= LEN_W'(byte_data);
        LEN_LO: begin
          if (w_xfer) begin
            r_len <= w_len_full;
            if (w_len_zero) begin
              // Empty image is a clean load: release the core.
              r_done     <= 1'b1;
              r_cpu_hold <= 1'b0;
            end else if (w_len_big) begin
              // Oversized image: reject, keep the core held.
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        DATA: if (w_xfer) r_csum <= r_csum ^ byte_data;
`endif
        WRITE: begin
          // Advance after the strobe so wr_addr/wr_data hold through WRITE.
          r_word_count <= w_count_next;
          r_wr_addr    <= r_wr_addr + ADDR_STEP;
`ifndef IMEM_LOADER_CHECKSUM_EN
          if (w_last_word) begin
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end
`endif
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (w_xfer) begin
            r_done <= 1'b1;
            if (byte_data != r_csum) r_error    <= 1'b1;
            else                     r_cpu_hold <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign wr_addr    = r_wr_addr;
  assign wr_data    = w_word;
  assign cpu_hold   = r_cpu_hold;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_word_count;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. Expected memory writes are queued
//   as bytes are driven and compared when wr_en is seen. Honours
//   IMEM_LOADER_CHECKSUM_EN by appending the XOR checksum byte.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 256;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] word_count;

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_writes = 0;
  bit          r_cont   = 0;
  wr_t         sb[$];
  logic [31:0] img[$];
`ifdef IMEM_LOADER_CHECKSUM_EN
  bit          r_csum_bad = 0;
`endif

  imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW), .LEN_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (wr_en) begin
      wr_t e;
      e = (sb.size() > 0) ? sb.pop_front() : '{addr: 32'hDEAD_BEEF, data: 32'hDEAD_BEEF};
      check("wr_addr", wr_addr, e.addr);
      check("wr_data", wr_data, e.data);
      check("rdy_in_write", {31'd0, byte_ready}, 32'd0);
      n_writes++;
    end
  end

  // Called at a negedge; returns at a negedge after the handshake.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!byte_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", {31'd0, byte_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (!r_cont) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Full load of img[] with header len; checks final status.
  task automatic run_load(input logic [15:0] len, input bit cont);
    int   wc0;
    int   exp_wc;
    bit   accept;
    bit   exp_err;
    logic [7:0] cs;
    cs      = 8'h00;
    accept  = (len != 16'd0) && (int'(len) <= MAXW);
    exp_err = (int'(len) > MAXW);
    exp_wc  = accept ? int'(len) : 0;
    wc0     = n_writes;
    pulse_start();
    r_cont = cont;
    send_byte(len[15:8]);
    send_byte(len[7:0]);
    if (accept) begin
      for (int i = 0; i < img.size(); i++) begin
        sb.push_back('{addr: BASE + 32'(4 * i), data: img[i]});
        for (int b = 0; b < 4; b++) begin
          cs ^= img[i][31-8*b -: 8];
          send_byte(img[i][31-8*b -: 8]);
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(r_csum_bad ? (cs ^ 8'h5A) : cs);
      exp_err = r_csum_bad;
`endif
    end
    byte_valid = 1'b0;
    r_cont     = 1'b0;
    wait_done();
    check("error",      {31'd0, error},    {31'd0, exp_err});
    check("cpu_hold",   {31'd0, cpu_hold}, {31'd0, exp_err});
    check("word_count", {16'd0, word_count}, 32'(exp_wc));
    check("addr_end",   wr_addr, BASE + 32'(4 * exp_wc));
    check("n_writes",   32'(n_writes - wc0), 32'(exp_wc));
    check("rdy_done",   {31'd0, byte_ready}, 32'd0);
    if (cs == 8'h00 && accept) begin
      // keeps the checksum variable observed in every build
      check("sb_drained", 32'(sb.size()), 32'd0);
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_hold",  {31'd0, cpu_hold},   32'd1);
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_wren",  {31'd0, wr_en},      32'd0);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_error", {31'd0, error},      32'd0);
    check("rst_wc",    {16'd0, word_count}, 32'd0);
    check("rst_addr",  wr_addr,             BASE);
    check("rst_data",  wr_data,             32'd0);

    // Case 1: no start, host byte offered for 20 cycles is ignored
    rst        = 1'b0;
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (20) begin
      @(negedge clk);
      check("idle_hold",  {31'd0, cpu_hold},   32'd1);
      check("idle_ready", {31'd0, byte_ready}, 32'd0);
      check("idle_wren",  {31'd0, wr_en},      32'd0);
    end
    byte_valid = 1'b0;
    check("idle_wc", {16'd0, word_count}, 32'd0);

    // Case 2: two-word image with gaps between bytes
    img = '{32'h2008_0005, 32'h8C09_0004};
    run_load(16'd2, 1'b0);

    // Case 3: empty image
    img.delete();
    run_load(16'd0, 1'b0);

    // Case 4: oversize header 257
    run_load(16'h0101, 1'b0);

    // Case 5: byte_valid held continuously
    img = '{32'h2008_0005, 32'h8C09_0004};
    run_load(16'd2, 1'b1);

    // Boundary: exactly MAX_WORDS words, last address BASE+0x3FC
    img.delete();
    for (int i = 0; i < MAXW; i++) img.push_back($urandom);
    run_load(16'(MAXW), 1'b1);

    // Case 6: reset after 6 data bytes
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    sb.push_back('{addr: BASE, data: 32'h2008_0005});
    send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h8C); send_byte(8'h09);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_hold",  {31'd0, cpu_hold},   32'd1);
    check("mid_rst_wc",    {16'd0, word_count}, 32'd0);
    check("mid_rst_ready", {31'd0, byte_ready}, 32'd0);
    check("mid_rst_done",  {31'd0, done},       32'd0);
    check("mid_rst_addr",  wr_addr,             BASE);
    rst = 1'b0;
    @(negedge clk);
    img = '{32'h2008_0005, 32'h8C09_0004};
    run_load(16'd2, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte: load fails, core stays held
    r_csum_bad = 1'b1;
    run_load(16'd2, 1'b0);
    r_csum_bad = 1'b0;
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
